// File: rtl/serdes_rx_framer_pkg.sv
// Shared types and constants for the serdes receive framer.
package serdes_frame_pkg;

  // Framer FSM states.
  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK
  } state_e;

  // Reason recorded for the most recently discarded frame.
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_LEN,
    ERR_CSUM,
    ERR_OVF
  } err_code_e;

  // Default start-of-frame marker.
  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/serdes_rx_framer_if.sv
// Valid/ready payload stream from the framer to its consumer.
// The framer drives data/last/valid; the consumer returns ready.
interface serdes_rx_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (output data, output last, output valid, input ready);
  modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/serdes_rx_framer_rx_spec_buffer.sv
// Speculative payload buffer: words are written at wr_spec and only become
// visible to the reader once wr_commit is moved up to wr_spec. A rollback
// throws away everything written since the last commit.
module rx_spec_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_last_i,
  input  logic                  commit_i,
  input  logic                  rollback_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;

  // Each entry carries the end-of-frame flag alongside the payload word.
  logic [DATA_WIDTH:0] mem [BUF_DEPTH];

  logic [PW-1:0] wr_spec_q, wr_spec_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] occupancy;
  logic          pop_eff;

  assign empty_o   = (rd_q == wr_commit_q);
  assign pop_eff   = pop_i && !empty_o;
  assign occupancy = wr_spec_q - rd_q;
  // A pop in this cycle frees its slot for a write in the same cycle.
  assign full_o    = ((occupancy - PW'(pop_eff)) == PW'(BUF_DEPTH));

  assign {rd_last_o, rd_data_o} = mem[rd_q[AW-1:0]];

  // Pointer next-state: write, rollback, commit and pop.
  always_comb begin
    wr_spec_d   = wr_spec_q;
    wr_commit_d = wr_commit_q;
    rd_d        = rd_q;
    if (wr_i)       wr_spec_d   = wr_spec_q + PW'(1);
    if (rollback_i) wr_spec_d   = wr_commit_q;
    if (commit_i)   wr_commit_d = wr_spec_q;
    if (pop_eff)    rd_d        = rd_q + PW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
      rd_q        <= '0;
    end else begin
      wr_spec_q   <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
      rd_q        <= rd_d;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_i) mem[wr_spec_q[AW-1:0]] <= {wr_last_i, wr_data_i};
  end

endmodule

// File: rtl/serdes_rx_framer.sv
// Receive framer: hunts for SOF, reads a length, buffers the payload
// speculatively and releases it only when the XOR checksum matches.
// Optional frame statistics counters: define SERDES_RX_FRAMER_STATS_EN.
module serdes_rx_framer
  import serdes_frame_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    BUF_DEPTH  = 16,
  parameter int                    MAX_LEN    = 15,
  parameter logic [DATA_WIDTH-1:0] SOF_WORD   = DATA_WIDTH'(DEFAULT_SOF)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  input  logic                      valid_i,
  serdes_rx_framer_if.master        out_if,
  output logic                      frame_ok_o,
  output logic                      err_o,
  output logic [1:0]                err_code_o
`ifdef SERDES_RX_FRAMER_STATS_EN
  ,
  output logic [15:0]               good_cnt_o,
  output logic [15:0]               bad_cnt_o
`endif
);

  localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);
  localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);

  state_e                state_q, state_d;
  err_code_e             err_code_q, err_code_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  frame_ok_q, frame_ok_d;
  logic                  err_q, err_d;

  logic buf_wr, buf_commit, buf_rollback, buf_full, buf_empty, buf_pop, wr_last;

  assign buf_pop      = out_if.valid && out_if.ready;
  assign out_if.valid = !buf_empty;
  assign wr_last      = (cnt_q == len_q - ONE);

  rx_spec_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_i       (buf_wr),
    .wr_data_i  (data_i),
    .wr_last_i  (wr_last),
    .commit_i   (buf_commit),
    .rollback_i (buf_rollback),
    .pop_i      (buf_pop),
    .full_o     (buf_full),
    .empty_o    (buf_empty),
    .rd_data_o  (out_if.data),
    .rd_last_o  (out_if.last)
  );

  // Frame delineation; only words with valid_i set move the FSM.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    err_code_d   = err_code_q;
    frame_ok_d   = 1'b0;
    err_d        = 1'b0;
    buf_wr       = 1'b0;
    buf_commit   = 1'b0;
    buf_rollback = 1'b0;
    if (valid_i) begin
      case (state_q)
        HUNT: begin
          if (data_i == SOF_WORD) state_d = LEN;
        end
        LEN: begin
          if (data_i == '0 || data_i > MAX_LEN_W) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = HUNT;
          end else begin
            len_d   = data_i;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (buf_full) begin
            // No room: drop the whole frame; its tail is hunted as noise.
            buf_rollback = 1'b1;
            err_d        = 1'b1;
            err_code_d   = ERR_OVF;
            state_d      = HUNT;
          end else begin
            buf_wr = 1'b1;
            acc_d  = acc_q ^ data_i;
            cnt_d  = cnt_q + ONE;
            if (wr_last) state_d = CHECK;
          end
        end
        CHECK: begin
          if (data_i == acc_q) begin
            buf_commit = 1'b1;
            frame_ok_d = 1'b1;
          end else begin
            buf_rollback = 1'b1;
            err_d        = 1'b1;
            err_code_d   = ERR_CSUM;
          end
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // FSM and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HUNT;
      err_code_q <= ERR_NONE;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      frame_ok_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      frame_ok_q <= frame_ok_d;
      err_q      <= err_d;
    end
  end

  assign frame_ok_o = frame_ok_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

`ifdef SERDES_RX_FRAMER_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  // Saturating good/bad frame counters, updated alongside the pulses.
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (frame_ok_d && good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
    if (err_d && bad_cnt_q != 16'hFFFF)       bad_cnt_d  = bad_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign good_cnt_o = good_cnt_q;
  assign bad_cnt_o  = bad_cnt_q;
`endif

endmodule

// File: tb/tb_serdes_rx_framer.sv
// Self-checking bench for serdes_rx_framer. Expected payload words and
// frame outcomes are derived from the frame contents (length, XOR of the
// payload, free buffer room) and compared against what the monitor records.
module tb_serdes_rx_framer;

  localparam int DW   = 8;
  localparam int MAXL = 15;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic          frame_ok_o, err_o;
  logic [1:0]    err_code_o;
`ifdef SERDES_RX_FRAMER_STATS_EN
  logic [15:0]   good_cnt_o, bad_cnt_o;
`endif

  serdes_rx_framer_if #(.DATA_WIDTH(DW)) out_if ();
  assign out_if.ready = ready_i;
  wire          valid_o = out_if.valid;
  wire          last_o  = out_if.last;
  wire [DW-1:0] data_o  = out_if.data;

  serdes_rx_framer #(.DATA_WIDTH(DW), .BUF_DEPTH(16), .MAX_LEN(MAXL), .SOF_WORD(8'hA5)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .out_if     (out_if),
    .frame_ok_o (frame_ok_o),
    .err_o      (err_o),
    .err_code_o (err_code_o)
`ifdef SERDES_RX_FRAMER_STATS_EN
    ,
    .good_cnt_o (good_cnt_o),
    .bad_cnt_o  (bad_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] exp_words[$];
  logic [8:0] obs_words[$];
  int         exp_ev[$];
  int         obs_ev[$];
  int         stall_viol = 0;
  logic       hold_prev = 1'b0;
  logic [8:0] hold_val = '0;
  bit         rdy_toggle = 1'b0;

  // Monitor: records accepted words, outcome pulses and stall violations.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (hold_prev && valid_o && ({last_o, data_o} !== hold_val)) stall_viol <= stall_viol + 1;
      hold_prev <= valid_o && !ready_i;
      hold_val  <= {last_o, data_o};
      if (valid_o && ready_i) obs_words.push_back({last_o, data_o});
      if (frame_ok_o) obs_ev.push_back(0);
      if (err_o) obs_ev.push_back(int'(err_code_o));
    end else begin
      hold_prev <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [7:0] w, input bit v);
    @(posedge clk);
    #1;
    data_i  = w;
    valid_i = v;
    if (rdy_toggle) ready_i = ~ready_i;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic clear_sb();
    exp_words.delete();
    obs_words.delete();
    exp_ev.delete();
    obs_ev.delete();
  endtask

  task automatic make_payload(input int len, input bit low, output logic [7:0] pl[$]);
    pl.delete();
    for (int i = 0; i < len; i++)
      pl.push_back(low ? 8'($urandom_range(0, 127)) : 8'($urandom));
  endtask

  // Sends SOF, length, payload and checksum, and records the expected outcome:
  // bad length -> LEN error (no payload sent); too little room -> OVF;
  // corrupted checksum -> CSUM; otherwise the payload is delivered.
  task automatic send_frame(input int len, input logic [7:0] pl[$], input bit bad, input int room);
    logic [7:0] csum;
    csum = 8'h00;
    drive(8'hA5, 1'b1);
    drive(len[7:0], 1'b1);
    if (len == 0 || len > MAXL) begin
      exp_ev.push_back(1);
      return;
    end
    foreach (pl[i]) csum ^= pl[i];
    if (bad) csum ^= 8'h01;
    foreach (pl[i]) drive(pl[i], 1'b1);
    drive(csum, 1'b1);
    if (len > room) exp_ev.push_back(3);
    else if (bad) exp_ev.push_back(2);
    else begin
      foreach (pl[i]) exp_words.push_back({(i == len - 1), pl[i]});
      exp_ev.push_back(0);
    end
  endtask

  task automatic drain(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 400; n++) begin
      drive(8'h00, 1'b0);
      if (!valid_o && obs_ev.size() >= exp_ev.size()) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (2) drive(8'h00, 1'b0);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_checks++; if (frame_ok_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got ok=%b err=%b expected 0/0", frame_ok_o, err_o); end
    n_checks++; if (err_code_o !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d expected 0", err_code_o); end
`ifdef SERDES_RX_FRAMER_STATS_EN
    n_checks++; if (good_cnt_o !== 16'd0 || bad_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", good_cnt_o, bad_cnt_o); end
`endif
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_good();
    logic [7:0] pl[$];
    bit to;
    clear_sb();
    ready_i = 1'b1;
    pl = '{8'h11, 8'h22, 8'h44};
    send_frame(3, pl, 1'b0, 99);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL good_early_valid: got %b expected 0", valid_o); end
    drive(8'h00, 1'b0);
    n_checks++; if (frame_ok_o !== 1'b1) begin n_fail++; $display("FAIL good_frame_ok: got %b expected 1", frame_ok_o); end
    n_checks++; if (valid_o !== 1'b1 || data_o !== 8'h11) begin n_fail++; $display("FAIL good_latency: got valid=%b data=%h expected 1/11", valid_o, data_o); end
    drain(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL good_drain: got timeout expected drained"); end
    n_checks++; if (obs_words.size() != exp_words.size()) begin n_fail++; $display("FAIL good_nwords: got %0d expected %0d", obs_words.size(), exp_words.size()); end
    foreach (exp_words[i]) if (i < obs_words.size()) begin
      n_checks++; if (obs_words[i] !== exp_words[i]) begin n_fail++; $display("FAIL good_word[%0d]: got %03h expected %03h", i, obs_words[i], exp_words[i]); end
    end
    n_checks++; if (obs_ev.size() != 1 || obs_ev[0] != 0) begin n_fail++; $display("FAIL good_events: got %0d events expected single frame_ok", obs_ev.size()); end
  endtask

  task automatic test_bad_csum();
    logic [7:0] pl[$];
    bit to;
    clear_sb();
    ready_i = 1'b1;
    pl = '{8'h10, 8'h20};
    send_frame(2, pl, 1'b1, 99);
    drive(8'h00, 1'b0);
    n_checks++; if (err_o !== 1'b1 || err_code_o !== 2'd2) begin n_fail++; $display("FAIL csum_err: got err=%b code=%0d expected 1/2", err_o, err_code_o); end
    drive(8'h00, 1'b0);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL csum_valid: got %b expected 0", valid_o); end
    make_payload(5, 1'b0, pl);
    send_frame(5, pl, 1'b0, 99);
    drain(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL csum_drain: got timeout expected drained"); end
    n_checks++; if (obs_words.size() != exp_words.size()) begin n_fail++; $display("FAIL csum_nwords: got %0d expected %0d", obs_words.size(), exp_words.size()); end
    foreach (exp_words[i]) if (i < obs_words.size()) begin
      n_checks++; if (obs_words[i] !== exp_words[i]) begin n_fail++; $display("FAIL csum_word[%0d]: got %03h expected %03h", i, obs_words[i], exp_words[i]); end
    end
    n_checks++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL csum_nevents: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
    foreach (exp_ev[i]) if (i < obs_ev.size()) begin
      n_checks++; if (obs_ev[i] != exp_ev[i]) begin n_fail++; $display("FAIL csum_event[%0d]: got %0d expected %0d", i, obs_ev[i], exp_ev[i]); end
    end
  endtask

  task automatic test_len_err();
    logic [7:0] pl[$];
    logic [7:0] none[$];
    bit to;
    clear_sb();
    ready_i = 1'b1;
    send_frame(0, none, 1'b0, 99);
    send_frame(16, none, 1'b0, 99);
    drive(8'h00, 1'b0);
    n_checks++; if (err_code_o !== 2'd1) begin n_fail++; $display("FAIL len_code: got %0d expected 1", err_code_o); end
    make_payload(MAXL, 1'b0, pl);
    send_frame(MAXL, pl, 1'b0, 99);
    drain(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL len_drain: got timeout expected drained"); end
    n_checks++; if (err_code_o !== 2'd1) begin n_fail++; $display("FAIL len_code_held: got %0d expected 1", err_code_o); end
    n_checks++; if (obs_words.size() != exp_words.size()) begin n_fail++; $display("FAIL len_nwords: got %0d expected %0d", obs_words.size(), exp_words.size()); end
    foreach (exp_words[i]) if (i < obs_words.size()) begin
      n_checks++; if (obs_words[i] !== exp_words[i]) begin n_fail++; $display("FAIL len_word[%0d]: got %03h expected %03h", i, obs_words[i], exp_words[i]); end
    end
    n_checks++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL len_nevents: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
    foreach (exp_ev[i]) if (i < obs_ev.size()) begin
      n_checks++; if (obs_ev[i] != exp_ev[i]) begin n_fail++; $display("FAIL len_event[%0d]: got %0d expected %0d", i, obs_ev[i], exp_ev[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pl[$];
    bit to;
    int len;
    bit bad;
    clear_sb();
    ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, MAXL);
      bad = (k != 0) && ($urandom_range(0, 3) == 0);
      make_payload(len, 1'b0, pl);
      send_frame(len, pl, bad, 99);
    end
    drain(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_drain: got timeout expected drained"); end
    n_checks++; if (obs_words.size() != exp_words.size()) begin n_fail++; $display("FAIL b2b_nwords: got %0d expected %0d", obs_words.size(), exp_words.size()); end
    foreach (exp_words[i]) if (i < obs_words.size()) begin
      n_checks++; if (obs_words[i] !== exp_words[i]) begin n_fail++; $display("FAIL b2b_word[%0d]: got %03h expected %03h", i, obs_words[i], exp_words[i]); end
    end
    n_checks++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL b2b_nevents: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
    foreach (exp_ev[i]) if (i < obs_ev.size()) begin
      n_checks++; if (obs_ev[i] != exp_ev[i]) begin n_fail++; $display("FAIL b2b_event[%0d]: got %0d expected %0d", i, obs_ev[i], exp_ev[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] pl[$];
    bit to;
    do_reset();
    clear_sb();
    ready_i = 1'b0;
    // 8 committed words leave room for 8; a 15-word frame must overflow.
    make_payload(8, 1'b1, pl);
    send_frame(8, pl, 1'b0, 16);
    make_payload(15, 1'b1, pl);
    send_frame(15, pl, 1'b0, 8);
    repeat (3) drive(8'h00, 1'b0);
    n_checks++; if (err_code_o !== 2'd3) begin n_fail++; $display("FAIL ovf_code: got %0d expected 3", err_code_o); end
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b expected 1", valid_o); end
    ready_i = 1'b1;
    drain(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL ovf_drain1: got timeout expected drained"); end
    n_checks++; if (obs_words.size() != 8) begin n_fail++; $display("FAIL ovf_drainable: got %0d expected 8", obs_words.size()); end
    // Exact fill: 15 + 1 words fit, one more word does not.
    ready_i = 1'b0;
    make_payload(15, 1'b1, pl);
    send_frame(15, pl, 1'b0, 16);
    make_payload(1, 1'b1, pl);
    send_frame(1, pl, 1'b0, 1);
    make_payload(1, 1'b1, pl);
    send_frame(1, pl, 1'b0, 0);
    repeat (3) drive(8'h00, 1'b0);
    ready_i = 1'b1;
    drain(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL ovf_drain2: got timeout expected drained"); end
    n_checks++; if (obs_words.size() != exp_words.size()) begin n_fail++; $display("FAIL ovf_nwords: got %0d expected %0d", obs_words.size(), exp_words.size()); end
    foreach (exp_words[i]) if (i < obs_words.size()) begin
      n_checks++; if (obs_words[i] !== exp_words[i]) begin n_fail++; $display("FAIL ovf_word[%0d]: got %03h expected %03h", i, obs_words[i], exp_words[i]); end
    end
    n_checks++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL ovf_nevents: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
    foreach (exp_ev[i]) if (i < obs_ev.size()) begin
      n_checks++; if (obs_ev[i] != exp_ev[i]) begin n_fail++; $display("FAIL ovf_event[%0d]: got %0d expected %0d", i, obs_ev[i], exp_ev[i]); end
    end
  endtask

  task automatic test_noise();
    logic [7:0] pl[$];
    bit to;
    int viol0;
    clear_sb();
    viol0 = stall_viol;
    ready_i = 1'b1;
    rdy_toggle = 1'b1;
    drive(8'h00, 1'b1);
    drive(8'hA4, 1'b1);
    drive(8'hFF, 1'b1);
    make_payload(4, 1'b0, pl);
    send_frame(4, pl, 1'b0, 99);
    drain(to);
    rdy_toggle = 1'b0;
    ready_i = 1'b1;
    n_checks++; if (to) begin n_fail++; $display("FAIL noise_drain: got timeout expected drained"); end
    n_checks++; if (stall_viol != viol0) begin n_fail++; $display("FAIL noise_stall_stable: got %0d changes expected 0", stall_viol - viol0); end
    n_checks++; if (obs_words.size() != exp_words.size()) begin n_fail++; $display("FAIL noise_nwords: got %0d expected %0d", obs_words.size(), exp_words.size()); end
    foreach (exp_words[i]) if (i < obs_words.size()) begin
      n_checks++; if (obs_words[i] !== exp_words[i]) begin n_fail++; $display("FAIL noise_word[%0d]: got %03h expected %03h", i, obs_words[i], exp_words[i]); end
    end
    n_checks++; if (obs_ev.size() != 1 || obs_ev[0] != 0) begin n_fail++; $display("FAIL noise_events: got %0d events expected single frame_ok", obs_ev.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pl[$];
    bit to;
    do_reset();
    clear_sb();
    ready_i = 1'b0;
    make_payload($urandom_range(3, 6), 1'b0, pl);
    send_frame(pl.size(), pl, 1'b0, 16);
    make_payload($urandom_range(3, 6), 1'b0, pl);
    send_frame(pl.size(), pl, 1'b0, 10);
    make_payload(2, 1'b0, pl);
    send_frame(2, pl, 1'b1, 4);
    repeat (2) drive(8'h00, 1'b0);
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_committed: got %b expected 1", valid_o); end
    n_checks++; if (obs_ev.size() != 3 || obs_ev[0] != 0 || obs_ev[1] != 0 || obs_ev[2] != 2) begin n_fail++; $display("FAIL rstmid_events: got %0d events expected ok,ok,csum", obs_ev.size()); end
`ifdef SERDES_RX_FRAMER_STATS_EN
    n_checks++; if (good_cnt_o !== 16'd2 || bad_cnt_o !== 16'd1) begin n_fail++; $display("FAIL stats_counts: got %0d/%0d expected 2/1", good_cnt_o, bad_cnt_o); end
`endif
    drive(8'hA5, 1'b1);
    drive(8'h05, 1'b1);
    drive(8'h33, 1'b1);
    drive(8'h44, 1'b1);
    do_reset();
    n_checks++; if (valid_o !== 1'b0 || frame_ok_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_cleared: got valid=%b ok=%b expected 0/0", valid_o, frame_ok_o); end
`ifdef SERDES_RX_FRAMER_STATS_EN
    n_checks++; if (good_cnt_o !== 16'd0 || bad_cnt_o !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", good_cnt_o, bad_cnt_o); end
`endif
    clear_sb();
    ready_i = 1'b1;
    make_payload(5, 1'b0, pl);
    send_frame(5, pl, 1'b0, 16);
    drain(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_drain: got timeout expected drained"); end
    n_checks++; if (obs_words.size() != exp_words.size()) begin n_fail++; $display("FAIL rstmid_nwords: got %0d expected %0d", obs_words.size(), exp_words.size()); end
    foreach (exp_words[i]) if (i < obs_words.size()) begin
      n_checks++; if (obs_words[i] !== exp_words[i]) begin n_fail++; $display("FAIL rstmid_word[%0d]: got %03h expected %03h", i, obs_words[i], exp_words[i]); end
    end
    n_checks++; if (obs_ev.size() != 1 || obs_ev[0] != 0) begin n_fail++; $display("FAIL rstmid_after_events: got %0d events expected single frame_ok", obs_ev.size()); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_csum();
    test_len_err();
    test_back_to_back();
    test_overflow();
    test_noise();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serdes_rx_framer.md
Name: serdes_rx_framer

Overview:
- Sits directly downstream of the serdes deserializer output.
- Consumes its valid-only parallel word stream, which has no backpressure.
- Delineates frames (SOF, length, payload, checksum) and stores payload speculatively in an internal buffer.
- Releases a frame to a valid/ready consumer only after its checksum passes; bad or oversize frames are rolled back and reported.

Parameters:
DATA_WIDTH, 8, word width; must match the serdes DATA_WIDTH.
BUF_DEPTH, 16, payload buffer entries; power of two, >= MAX_LEN.
MAX_LEN, 15, maximum legal payload length in words; < 2**DATA_WIDTH.
SOF_WORD, 8'hA5, start-of-frame marker (DATA_WIDTH wide).

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_i  input  1  synchronous, active-high reset.
data_i  input  DATA_WIDTH  word from the deserializer.
valid_i  input  1  data_i valid; single-cycle qualifier, no ready returned.
data_o  output  DATA_WIDTH  payload word to the consumer.
last_o  output  1  marks the final payload word of a frame; qualified by valid_o.
valid_o  output  1  buffer holds a committed word.
ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
frame_ok_o  output  1  one-cycle pulse when a frame is committed.
err_o  output  1  one-cycle pulse when a frame is discarded.
err_code_o  output  2  0 none, 1 LEN, 2 CSUM, 3 OVF; held until the next err_o.

Behaviour:
- Reset: state HUNT; all pointers 0; valid_o, last_o, frame_ok_o, err_o = 0; err_code_o = 0; checksum accumulator 0.
- Memory contents are not reset; data_o is don't-care while valid_o = 0.
- Pointers: wr_spec, wr_commit, rd; each $clog2(BUF_DEPTH)+1 bits wide, wrapping naturally.
- Empty: rd == wr_commit. Full: wr_spec - rd == BUF_DEPTH.
- valid_o = (rd != wr_commit). data_o and last_o are a combinational read of mem[rd].
- A pop advances rd; pops are independent of the FSM.
- The FSM advances only on cycles with valid_i = 1.
- HUNT: data_i == SOF_WORD -> LEN; any other word is ignored.
- LEN:
  - data_i == 0 or data_i > MAX_LEN -> err (code 1), go to HUNT.
  - Otherwise latch len = data_i, clear count and accumulator, go to PAYLOAD.
- PAYLOAD, buffer not full:
  - Write {last = (count == len-1), data_i} at wr_spec; wr_spec++.
  - acc ^= data_i; count++.
  - When count reaches len -> CHECK.
- PAYLOAD, buffer full on the incoming word:
  - Drop the word, set wr_spec = wr_commit, err (code 3), go to HUNT.
  - Remaining words of that frame are then hunted through as noise.
- CHECK:
  - data_i == acc -> wr_commit = wr_spec, frame_ok_o pulse, go to HUNT.
  - Otherwise wr_spec = wr_commit, err (code 2), go to HUNT.
- Latency: the first payload word of a good frame is visible on valid_o in the cycle after the checksum word is sampled.
- Full is evaluated with the current-cycle pop included, so a same-cycle pop frees a slot.
- A pop together with a commit or rollback is legal; rd never passes wr_commit.
- Back-to-back frames need no idle cycles. A SOF inside a payload is treated as data (no resync).
- Reset mid-frame discards all speculative and committed data.

Optional Feature:
- Macro: SERDES_RX_FRAMER_STATS_EN.
- With it defined:
  - Adds outputs good_cnt_o[15:0] and bad_cnt_o[15:0].
  - Reset to 0; incremented on frame_ok_o and err_o respectively.
  - Counters saturate at 16'hFFFF.
- Without it: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package serdes_frame_pkg:
  - State enum {HUNT, LEN, PAYLOAD, CHECK}.
  - Error enum err_code_e {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_OVF}.
  - Default SOF constant.
- Sub-module rx_spec_buffer (not natural to split further):
  - Holds memory plus wr_spec/wr_commit/rd.
  - Ports: write, commit, rollback, pop, full, empty.
  - The FSM stays in serdes_rx_framer.

Test Plan:
- Good frame, back-to-back: A5,03,11,22,44,77 with ready_i = 1 -> frame_ok_o one cycle after the 77; data_o 11,22,44 with last_o on the 44; err_o never.
- Bad checksum: A5,02,10,20,31 -> err_o, code 2; valid_o stays 0; a following good frame passes intact.
- Length errors: A5,00 -> code 1; A5,10 (16 > MAX_LEN) -> code 1; the FSM returns to HUNT and the next A5 is accepted.
- Overflow: ready_i = 0, commit an 8-word frame, then send a 15-word frame -> err code 3 on its 9th payload word; afterwards exactly 8 words are drainable.
- Noise and backpressure: 00,A4,FF then a good 4-word frame with ready_i toggling 1010 -> noise ignored; all 4 words delivered in order; data_o/last_o stable while valid_o && !ready_i.
- Reset mid-PAYLOAD plus stats: with STATS_EN, 2 good frames and 1 bad -> good_cnt_o = 2, bad_cnt_o = 1; rst_i during the next frame -> counters and valid_o = 0; the next frame decodes correctly.
